// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types for the simpleCPU multi-cycle control path:
//   - state_t      : FSM state encoding (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK)
//   - OP_*         : supported 7-bit major opcodes
//   - alu_class_t  : instruction class, encoded directly as the 2-bit alu_op
//   - op_decode_t  : result of decoding an opcode (legal flag + class)
//   - decode_opcode: opcode -> op_decode_t
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  // The class value doubles as the alu_op presented to the ALU control decoder.
  typedef enum logic [1:0] {
    CLS_R  = 2'b00,
    CLS_LW = 2'b01,
    CLS_I  = 2'b10,
    CLS_SW = 2'b11
  } alu_class_t;

  typedef struct packed {
    logic       legal;
    alu_class_t cls;
  } op_decode_t;

  // Unsupported opcodes report legal = 0; their class is don't-care (R).
  function automatic op_decode_t decode_opcode(input logic [6:0] op);
    op_decode_t d;
    d.legal = 1'b1;
    d.cls   = CLS_R;
    case (op)
      OP_R:    d.cls = CLS_R;
      OP_I:    d.cls = CLS_I;
      OP_LW:   d.cls = CLS_LW;
      OP_SW:   d.cls = CLS_SW;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts cycles a memory request waits for ready and flags a timeout when the
// count has reached TIMEOUT_CYCLES while ready is still low.
// Ports:
//   i_clk      core clock
//   i_reset    synchronous active-high reset (clears the counter)
//   i_clear    restart counting from zero (entry into a requesting state)
//   i_req      a memory request is outstanding this cycle
//   i_ready    the memory completed the request this cycle
//   o_timeout  combinational: req && !ready && count == TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_count;
  logic             w_waiting;

  assign w_waiting = i_req & ~i_ready;
  // A ready on the boundary cycle suppresses the timeout.
  assign o_timeout = w_waiting & (r_count == LIMIT);

  // Wait counter; stops at LIMIT, the owner clears it when it leaves on timeout.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_waiting && (r_count != LIMIT)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the simpleCPU core. Sequences one instruction at a time
// through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, handshakes with the
// instruction and data memories (with a watchdog) and counts retirements.
// Ports:
//   clk, reset      core clock, synchronous active-high reset
//   opcode          instr[6:0] from the IR (valid from DECODE onward)
//   imem_ready      instruction word valid this cycle
//   dmem_ready      data access complete this cycle
//   imem_req        instruction fetch request (FETCH)
//   dmem_req/we     data request / write enable (MEMORY; we only for SW)
//   ir_write        latch fetched word into IR (FETCH with imem_ready)
//   pc_write        PC <= PC+4 (FETCH with imem_ready)
//   alu_op          00 R, 10 I, 01 LW, 11 SW (EXECUTE..WRITEBACK)
//   alu_src_b       1 = immediate operand (I/LW/SW)
//   reg_write       register write enable (WRITEBACK)
//   mem_to_reg      writeback selects load data (WRITEBACK of LW)
//   illegal_instr   one-cycle pulse in DECODE on an unsupported opcode
//   bus_error       one-cycle pulse on a memory handshake timeout
//   instret         retired instruction count (wraps)
// All outputs read 0 while reset is high.
// -----------------------------------------------------------------------------
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           alu_op,
  output logic                 alu_src_b,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [INSTRET_W-1:0] instret
);

  state_t                 r_state;
  state_t                 w_next_state;
  alu_class_t             r_class;
  logic [INSTRET_W-1:0]   r_instret;
  op_decode_t             w_dec;
  logic                   w_req;
  logic                   w_ready;
  logic                   w_timeout;
  logic                   w_clear;
  logic                   w_retire;

  assign w_dec = decode_opcode(opcode);

  // Select which memory handshake the watchdog is observing.
  always_comb begin
    w_req   = 1'b0;
    w_ready = 1'b0;
    if (r_state == ST_FETCH) begin
      w_req   = 1'b1;
      w_ready = imem_ready;
    end else if (r_state == ST_MEMORY) begin
      w_req   = 1'b1;
      w_ready = dmem_ready;
    end else begin
      w_req   = 1'b0;
      w_ready = 1'b0;
    end
  end

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (w_clear),
    .i_req    (w_req),
    .i_ready  (w_ready),
    .o_timeout(w_timeout)
  );

  // Next-state, retire and watchdog-clear decode.
  always_comb begin
    w_next_state = r_state;
    w_retire     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (imem_ready) begin
          w_next_state = ST_DECODE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (w_dec.legal) begin
          w_next_state = ST_EXECUTE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_EXECUTE: begin
        case (r_class)
          CLS_R, CLS_I: w_next_state = ST_WRITEBACK;
          default:      w_next_state = ST_MEMORY;
        endcase
      end
      ST_MEMORY: begin
        if (dmem_ready) begin
          if (r_class == CLS_SW) begin
            w_next_state = ST_FETCH;
            w_retire     = 1'b1;
          end else begin
            w_next_state = ST_WRITEBACK;
          end
        end else if (w_timeout) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        w_next_state = ST_FETCH;
        w_retire     = 1'b1;
      end
      default: begin
        w_next_state = ST_FETCH;
      end
    endcase
    // Restart the wait count on every entry to a requesting state; a timeout
    // re-enters FETCH from FETCH, so it counts as an entry too.
    w_clear = (((w_next_state == ST_FETCH) || (w_next_state == ST_MEMORY)) &&
               (w_next_state != r_state)) || w_timeout;
  end

  // State, class and retire-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_class   <= CLS_R;
      r_instret <= {INSTRET_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if ((r_state == ST_DECODE) && w_dec.legal) begin
        r_class <= w_dec.cls;
      end else begin
        r_class <= r_class;
      end
      if (w_retire) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end else begin
        r_instret <= r_instret;
      end
    end
  end

  // Output decode; strobes only ever assert in their own state.
  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    alu_op        = 2'b00;
    alu_src_b     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end else begin
            bus_error = w_timeout;
          end
        end
        ST_DECODE: begin
          illegal_instr = ~w_dec.legal;
        end
        ST_EXECUTE: begin
          alu_op    = r_class;
          alu_src_b = (r_class != CLS_R);
        end
        ST_MEMORY: begin
          alu_op    = r_class;
          alu_src_b = (r_class != CLS_R);
          dmem_req  = 1'b1;
          dmem_we   = (r_class == CLS_SW);
          bus_error = w_timeout;
        end
        ST_WRITEBACK: begin
          alu_op     = r_class;
          alu_src_b  = (r_class != CLS_R);
          reg_write  = 1'b1;
          mem_to_reg = (r_class == CLS_LW);
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end else begin
      imem_req = 1'b0;
    end
  end

  assign instret = reset ? {INSTRET_W{1'b0}} : r_instret;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main control FSM for the simpleCPU core. It sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- It drives the 2-bit alu_op consumed by the ALU control decoder, plus register-file, PC, IR and memory strobes.
- Handshakes with instruction and data memory via req/ready, with a watchdog timeout.
- Counts retired instructions.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a memory req may wait for ready before bus_error.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward.
- imem_ready  in  1  instruction memory data valid this cycle.
- dmem_ready  in  1  data memory access complete this cycle.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable (SW).
- ir_write  out  1  latch fetched word into the IR.
- pc_write  out  1  PC <= PC+4.
- alu_op  out  2  00 R-type, 10 I-type, 01 LW, 11 SW.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback source: 1 = load data, 0 = ALU result.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- bus_error  out  1  one-cycle pulse on a memory handshake timeout.
- instret  out  INSTRET_W  retired instruction count.

Behaviour:
- Reset:
  - While reset is high on an edge: state <= FETCH, class <= R, wait counter <= 0, instret <= 0.
  - All outputs are forced to 0 combinationally while reset is high.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK. Encoding is in the package.
- Opcode classes, latched into a class register in DECODE:
  - 0110011 = R.
  - 0010011 = I.
  - 0000011 = LW.
  - 0100011 = SW.
  - Anything else = ILLEGAL.
- Output timing:
  - alu_op and alu_src_b are Moore outputs from the class register, held constant from EXECUTE through WRITEBACK.
  - alu_src_b = 1 for I, LW and SW.
- FETCH:
  - imem_req = 1.
  - If imem_ready: ir_write = 1 and pc_write = 1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - Always exactly 1 cycle; latch the class.
  - If ILLEGAL: illegal_instr = 1 this cycle, then go to FETCH. No retire.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Always exactly 1 cycle.
  - R or I: go to WRITEBACK.
  - LW or SW: go to MEMORY.
- MEMORY:
  - dmem_req = 1; dmem_we = 1 if SW.
  - On dmem_ready: SW goes to FETCH and retires; LW goes to WRITEBACK.
- WRITEBACK:
  - reg_write = 1; mem_to_reg = 1 if LW.
  - Always exactly 1 cycle, then go to FETCH and retire.
- Retire: instret increments by 1 on the leaving edge. It wraps modulo 2^INSTRET_W.
- Latency with zero-wait memory:
  - R / I: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - Each memory wait cycle adds 1.
- Watchdog:
  - The wait counter clears on entry to FETCH or MEMORY and increments each cycle req is high without ready.
  - When it reaches TIMEOUT_CYCLES with ready still low: bus_error = 1 for that cycle, go to FETCH, no retire, and no ir_write, pc_write or reg_write.
  - A ready arriving in the same cycle as the count reaching TIMEOUT_CYCLES wins: normal transition, no bus_error.
- Reset mid-instruction: aborts immediately. The next cycle after reset deasserts is FETCH with imem_req = 1, and no retire is credited.
- No strobe (ir_write, pc_write, reg_write, dmem_req) is ever asserted outside its state.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum.
  - opcode localparams (OP_R, OP_I, OP_LW, OP_SW).
  - alu_op class enum (2-bit, values as above).
- Sub-module mem_watchdog: wait counter plus timeout compare. Parameter TIMEOUT_CYCLES; inputs req and ready, plus a clear; output timeout.
- Next-state and output decode stay in multicycle_control.

Test Plan:
- R-type ADD, zero-wait memory:
  - Stimulus: opcode = 0110011, imem_ready = 1.
  - Response: states F-D-E-W; reg_write = 1 for 1 cycle in WRITEBACK with alu_op = 00 and alu_src_b = 0; instret goes 0 -> 1 after 4 cycles.
- LW with dmem_ready delayed 3 cycles:
  - Stimulus: opcode = 0000011, dmem_ready low for 3 cycles in MEMORY.
  - Response: dmem_req held 4 cycles with dmem_we = 0; WRITEBACK follows with mem_to_reg = 1 and alu_op = 01; 8 cycles total.
- SW:
  - Stimulus: opcode = 0100011.
  - Response: dmem_we = 1 with dmem_req; reg_write never asserted; alu_op = 11; instret +1; back in FETCH after 4 cycles.
- Illegal opcode:
  - Stimulus: opcode = 1111111.
  - Response: illegal_instr pulses 1 cycle in DECODE; next state FETCH; instret unchanged; reg_write and dmem_req stay 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, imem_ready held 0.
  - Response: bus_error pulses in the 5th FETCH cycle; ir_write never asserted; FETCH restarts with the counter cleared.
  - Repeat with ready arriving on the boundary cycle: no bus_error.
- Reset in MEMORY of an LW:
  - Stimulus: assert reset for 1 cycle.
  - Response: all outputs 0 during reset; next cycle FETCH with imem_req = 1; instret = 0.
